// File: rtl/bus_req_pkg.sv
// Shared types and default parameters for the req/gnt requester agent.
package bus_req_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_RELEASE,
        ST_GAP
    } bus_req_state_e;

    localparam int unsigned LEN_W_DEF      = 4;
    localparam int unsigned TO_CYCLES_DEF  = 16;
    localparam int unsigned GAP_CYCLES_DEF = 2;

endpackage

// File: rtl/bus_requester_if.sv
// Command, arbiter and beat signals of one requester slot.
interface bus_requester_if #(
    parameter int unsigned LEN_W = 4
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             req;
    logic             gnt;
    logic             xfer_valid;
    logic             xfer_last;
    logic [LEN_W-1:0] xfer_beat;
    logic             busy;
    logic             timeout_err;
    logic             abort_err;

    modport master (
        input  cmd_valid, cmd_len, gnt,
        output cmd_ready, req, xfer_valid, xfer_last, xfer_beat,
               busy, timeout_err, abort_err
    );

    modport slave (
        output cmd_valid, cmd_len, gnt,
        input  cmd_ready, req, xfer_valid, xfer_last, xfer_beat,
               busy, timeout_err, abort_err
    );

endinterface

// File: rtl/bus_requester.sv
// Requester agent: request, burst, release and back-off for one arbiter slot.
//   state   | meaning
//   IDLE    | ready for a command
//   REQ     | req high, waiting for gnt or timeout
//   XFER    | driving beats while gnt holds
//   RELEASE | req low, waiting for the arbiter's registered gnt to drop
//   GAP     | back-off before the next command
module bus_requester
    import bus_req_pkg::*;
#(
    parameter int unsigned LEN_W      = LEN_W_DEF,
    parameter int unsigned TO_CYCLES  = TO_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    bus_requester_if.master  bus
);

    localparam int unsigned WAIT_W = $clog2(TO_CYCLES + 1);
    localparam int unsigned GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] TO_LAST  = WAIT_W'(TO_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);

    bus_req_state_e    state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              abort_q, abort_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            gap_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        gap_d   = gap_q;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    len_d   = bus.cmd_len;
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // The pulse cycle itself ignores gnt; a grant sampled on the
                // edge where the count would reach TO_CYCLES has already won.
                if (wait_q == TO_LAST) begin
                    state_d = ST_RELEASE;
                end else if (bus.gnt) begin
                    beat_d  = '0;
                    state_d = ST_XFER;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_XFER: begin
                if (beat_q == len_q) begin
                    state_d = ST_RELEASE;
                end else if (bus.gnt) begin
                    beat_d = beat_q + LEN_W'(1);
                end else begin
                    abort_d = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!bus.gnt) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.req         = (state_q == ST_REQ) || (state_q == ST_XFER);
    assign bus.xfer_valid  = (state_q == ST_XFER);
    assign bus.xfer_last   = (state_q == ST_XFER) && (beat_q == len_q);
    assign bus.xfer_beat   = (state_q == ST_XFER) ? beat_q : '0;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.timeout_err = (state_q == ST_REQ) && (wait_q == TO_LAST);
    assign bus.abort_err   = abort_q;

endmodule
